// File: rtl/onehot_req_encoder_if.sv
// Request/handshake bundle for onehot_req_encoder.
// The slave side is the encoder itself; the master side belongs to the request
// sources and the consumer.
interface onehot_req_encoder_if;
  logic       enablePin;  // active-low capture enable
  logic [3:0] req;        // request lines, decoder-output bit order
  logic       ready;      // consumer accepts code this cycle
  logic       valid;      // code holds an issued request
  logic [1:0] code;       // encoded request (3 - bit index)
  logic [3:0] pending;    // captured but not yet issued
  logic       multi;      // sticky: 2+ masked request bits at one edge

  modport master (
    output enablePin, req, ready,
    input  valid, code, pending, multi
  );

  modport slave (
    input  enablePin, req, ready,
    output valid, code, pending, multi
  );
endinterface

// File: rtl/onehot_req_encoder.sv
// onehot_req_encoder: sequential inverse of the active-low-enabled 2-to-4
// one-hot decoder. Requests are merged into a pending mask and issued one per
// cycle as a 2-bit code over valid/ready. The code is 3 - bit index, so
// req[3] maps to 00 and req[0] maps to 11, matching the decoder.
// All outputs come straight from flops; req/ready only affect next state.
module onehot_req_encoder #(
  parameter bit PRIO_HIGH = 1'b1  // 1: req[3] first, 0: req[0] first
) (
  input logic                  clk,
  input logic                  rst,
  onehot_req_encoder_if.slave  bus
);

  // Priority pick over the candidate mask: {found, bitIndex}.
  function automatic logic [2:0] pickBit(input logic [3:0] cand, input logic highFirst);
    logic [2:0] result;
    result = 3'b000;
    if (highFirst) begin
      casez (cand)
        4'b1???: result = 3'b111;
        4'b01??: result = 3'b110;
        4'b001?: result = 3'b101;
        4'b0001: result = 3'b100;
        default: result = 3'b000;
      endcase
    end else begin
      casez (cand)
        4'b???1: result = 3'b100;
        4'b??10: result = 3'b101;
        4'b?100: result = 3'b110;
        4'b1000: result = 3'b111;
        default: result = 3'b000;
      endcase
    end
    return result;
  endfunction

  // True when at least two bits of the mask are set.
  function automatic logic atLeastTwo(input logic [3:0] m);
    return (m[0] & m[1]) | (m[0] & m[2]) | (m[0] & m[3]) |
           (m[1] & m[2]) | (m[1] & m[3]) | (m[2] & m[3]);
  endfunction

  logic       valid_r;
  logic [1:0] code_r;
  logic [3:0] pending_r;
  logic       multi_r;

  logic [3:0] maskedReq_s;
  logic [3:0] cand_s;
  logic       load_s;
  logic [2:0] pick_s;
  logic       validNext_s;
  logic [1:0] codeNext_s;
  logic [3:0] pendingNext_s;
  logic       multiNext_s;

  // Gate requests, form candidates and compute the next register contents.
  always_comb begin
    maskedReq_s   = bus.enablePin ? 4'b0000 : bus.req;
    cand_s        = pending_r | maskedReq_s;
    load_s        = ~valid_r | bus.ready;
    pick_s        = pickBit(cand_s, PRIO_HIGH);
    validNext_s   = valid_r;
    codeNext_s    = code_r;
    pendingNext_s = cand_s;
    multiNext_s   = multi_r | atLeastTwo(maskedReq_s);
    if (load_s) begin
      if (pick_s[2]) begin
        // A request raised this edge and selected now is consumed here.
        validNext_s   = 1'b1;
        codeNext_s    = 2'd3 - pick_s[1:0];
        pendingNext_s = cand_s & ~(4'b0001 << pick_s[1:0]);
      end else begin
        // Nothing to send: the slot empties, code keeps its last value.
        validNext_s   = 1'b0;
        codeNext_s    = code_r;
        pendingNext_s = 4'b0000;
      end
    end else begin
      // Stalled: output slot frozen, new requests still merge into pending.
      validNext_s   = valid_r;
      codeNext_s    = code_r;
      pendingNext_s = cand_s;
    end
  end

  // State registers; reset discards any in-flight code and pending requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r   <= 1'b0;
      code_r    <= 2'b00;
      pending_r <= 4'b0000;
      multi_r   <= 1'b0;
    end else begin
      valid_r   <= validNext_s;
      code_r    <= codeNext_s;
      pending_r <= pendingNext_s;
      multi_r   <= multiNext_s;
    end
  end

  assign bus.valid   = valid_r;
  assign bus.code    = code_r;
  assign bus.pending = pending_r;
  assign bus.multi   = multi_r;

endmodule

// File: doc/onehot_req_encoder.md
Name: onehot_req_encoder

Overview:
- Sequential inverse of the team's active-low-enabled 2-to-4 one-hot decoder.
- Captures 4 request lines (decoder-output bit order) into a pending mask and issues each pending request as a 2-bit code over a valid/ready handshake.
- Uses the same code mapping as the decoder, so code fed back into the decoder reproduces the request bit: req[3]->00, req[2]->01, req[1]->10, req[0]->11.
- Sits between request sources and the decoder/consumer.

Parameters:
PRIO_HIGH, 1, 1: req[3] is highest priority (lowest code first); 0: req[0] is highest priority.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
enablePin  input  1  active-low capture enable; 1 = req ignored
req  input  4  request lines, any number may be high
ready  input  1  consumer accepts code this cycle
valid  output  1  code holds an issued request
code  output  2  encoded request (3 - bit index)
pending  output  4  requests captured but not yet issued
multi  output  1  sticky flag: 2+ masked req bits high at one edge

Behaviour:
- Reset (async, any time, including mid-handshake):
  - pending=0000, valid=0, code=00, multi=0.
  - In-flight code is discarded; no partial state survives.
- Masked requests: mreq = enablePin ? 0000 : req.
- Candidate set: cand = pending | mreq.
- Load condition: load = !valid | ready.
- On a clock edge with load=1 and cand != 0:
  - Select bit k from cand by priority (PRIO_HIGH=1: highest index wins; PRIO_HIGH=0: lowest index wins).
  - valid<=1, code<=3-k.
  - pending<=cand with bit k cleared.
- On a clock edge with load=1 and cand == 0: valid<=0; code holds its last value; pending<=0000.
- On a clock edge with load=0 (valid & !ready):
  - valid and code hold, and code must stay stable while stalled.
  - pending<=cand.
- Latency: req sampled at edge N gives valid/code at edge N (visible from cycle N+1) if the output slot is free. No combinational path from req or ready to any output.
- Throughput: one code per cycle with ready held high.
- Duplicate request: a req bit already pending merges into it; no double issue.
- A req bit equal to the code currently held in the output register re-enters pending and is issued again later. This is intentional: a new event.
- A req bit raised in the same edge it would be selected is consumed by that load and does not remain pending.
- enablePin=1 blocks capture only. Pending requests continue draining through the handshake.
- multi: set at any edge where popcount(mreq)>=2; cleared only by rst.
- All state is registered. Outputs come directly from flops.

Test Plan:
- Reset/idle: assert rst mid-stall with valid=1, code=01, pending=0100 -> next cycle valid=0, code=00, pending=0000, multi=0; release rst, req=0000 -> outputs stay idle.
- Single request per code, ready=1, enablePin=0: pulse req=1000,0100,0010,0001 on consecutive edges -> code 00,01,10,11 on consecutive cycles, valid=1 each, multi=0; then valid=0.
- Priority/multi, PRIO_HIGH=1, ready=1: one-cycle pulse req=0101 -> code=01 next cycle, then code=11, pending 0001->0000, multi=1 and sticky. Repeat with PRIO_HIGH=0 -> order 11 then 01.
- Backpressure: ready=0, pulse req=1000 then req=0010 -> valid=1, code=00 held stable, pending=0010; raise ready for 2 cycles -> codes 00 then 10 transferred, valid=0 after.
- Enable gating: enablePin=1, req=1111 for 3 cycles -> pending=0000, valid=0, multi=0. With pending=0011 and valid=1 from before, set enablePin=1, ready=1 -> codes 10, 11 still drain.
- Re-request/merge: valid=1, code=00, ready=0, req=1000 pulsed twice -> pending=1000 (single entry); raise ready -> code 00 issued twice total, then valid=0.
